// File: rtl/waveform_oscillator.sv
// Phase-accumulator voice oscillator: rising/falling saw, square with duty, triangle.
// Waveform shape and duty are latched only at period boundaries (carry) or on sync.
module waveform_oscillator #(
   parameter int OUT_W  = 8,
   parameter int FREQ_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              sync,
   input  logic [1:0]        mode,
   input  logic [FREQ_W-1:0] frequency_control,
   input  logic [OUT_W-1:0]  duty,
   output logic [OUT_W-1:0]  wave_out,
   output logic              wrap
);

   localparam logic [1:0] MODE_SAW_UP   = 2'd0;
   localparam logic [1:0] MODE_SAW_DOWN = 2'd1;
   localparam logic [1:0] MODE_SQUARE   = 2'd2;
   localparam logic [1:0] MODE_TRIANGLE = 2'd3;

   logic [ACC_W-1:0] phase_reg;
   logic [1:0]       act_mode_reg;
   logic [OUT_W-1:0] act_duty_reg;
   logic [OUT_W-1:0] wave_reg;
   logic             wrap_reg;

   logic [ACC_W:0]   phase_sum;
   logic [ACC_W-1:0] phase_next;
   logic             carry;
   logic [OUT_W-1:0] p;
   logic [OUT_W-1:0] tri_ramp;
   logic [OUT_W-1:0] tri_wave;
   logic [OUT_W-1:0] square_wave;
   logic [OUT_W-1:0] wave_next;

   // One extra bit on the adder exposes the carry that marks a period boundary.
   assign phase_sum  = {1'b0, phase_reg} + {{(ACC_W + 1 - FREQ_W){1'b0}}, frequency_control};
   assign phase_next = phase_sum[ACC_W-1:0];
   assign carry      = phase_sum[ACC_W];
   assign p          = phase_reg[ACC_W-1 -: OUT_W];

   // Triangle: doubled ramp on the lower bits, mirrored during the second half-period.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_tri
         if (gi == 0) begin : g_lsb
            assign tri_ramp[gi] = 1'b0;
         end else begin : g_bit
            assign tri_ramp[gi] = p[gi-1];
         end
         assign tri_wave[gi] = tri_ramp[gi] ^ p[OUT_W-1];
      end
   endgenerate

   assign square_wave = (p < act_duty_reg) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   always_comb begin
      wave_next = p;
      case (act_mode_reg)
         MODE_SAW_UP:   wave_next = p;
         MODE_SAW_DOWN: wave_next = ~p;
         MODE_SQUARE:   wave_next = square_wave;
         MODE_TRIANGLE: wave_next = tri_wave;
         default:       wave_next = p;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_reg    <= '0;
         act_mode_reg <= MODE_SAW_UP;
         act_duty_reg <= '0;
         wave_reg     <= '0;
         wrap_reg     <= 1'b0;
      end else if (sync) begin
         phase_reg    <= '0;
         act_mode_reg <= mode;
         act_duty_reg <= duty;
         wave_reg     <= wave_next;
         wrap_reg     <= 1'b0;
      end else if (enable) begin
         phase_reg <= phase_next;
         wave_reg  <= wave_next;
         wrap_reg  <= carry;
         // New shape starts cleanly with the first sample of the next period.
         if (carry) begin
            act_mode_reg <= mode;
            act_duty_reg <= duty;
         end
      end else begin
         wrap_reg <= 1'b0;
      end
   end

   assign wave_out = wave_reg;
   assign wrap     = wrap_reg;

endmodule

// File: tb/tb_waveform_oscillator.sv
// Directed bench for waveform_oscillator: vector table on an 8-bit accumulator,
// plus hand sequences for async reset and a 16-bit accumulator.
module tb_waveform_oscillator;

   logic       clk;
   logic       reset;
   logic       enable, sync;
   logic [1:0] mode;
   logic [7:0] fc, duty;
   logic [7:0] wave_out;
   logic       wrap;

   logic       w_enable, w_sync;
   logic [1:0] w_mode;
   logic [7:0] w_fc, w_duty;
   logic [7:0] w_wave_out;
   logic       w_wrap;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         tag;
      logic       rst;
      logic       en;
      logic       sy;
      logic [1:0] mode;
      logic [7:0] fc;
      logic [7:0] duty;
      logic [7:0] exp_wave;
      logic       exp_wrap;
   } vec_t;

   vec_t vecs[$];

   waveform_oscillator #(.OUT_W(8), .FREQ_W(8), .ACC_W(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sync(sync), .mode(mode),
      .frequency_control(fc), .duty(duty), .wave_out(wave_out), .wrap(wrap)
   );

   waveform_oscillator #(.OUT_W(8), .FREQ_W(8), .ACC_W(16)) dut_w (
      .clk(clk), .reset(reset), .enable(w_enable), .sync(w_sync), .mode(w_mode),
      .frequency_control(w_fc), .duty(w_duty), .wave_out(w_wave_out), .wrap(w_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input int tag, input logic rst, input logic en, input logic sy,
                               input logic [1:0] m, input logic [7:0] f, input logic [7:0] d,
                               input logic [7:0] ew, input logic ewr);
      vec_t v;
      v.tag = tag; v.rst = rst; v.en = en; v.sy = sy; v.mode = m;
      v.fc = f; v.duty = d; v.exp_wave = ew; v.exp_wrap = ewr;
      vecs.push_back(v);
   endfunction

   function automatic void rs(input int tag);
      add(tag, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
   endfunction

   function automatic void s(input int tag, input logic [1:0] m, input logic [7:0] f, input logic [7:0] d);
      add(tag, 1'b0, 1'b0, 1'b1, m, f, d, 8'd0, 1'b0);
   endfunction

   function automatic void e(input int tag, input logic [1:0] m, input logic [7:0] f, input logic [7:0] d,
                             input logic [7:0] ew, input logic ewr);
      add(tag, 1'b0, 1'b1, 1'b0, m, f, d, ew, ewr);
   endfunction

   function automatic void h(input int tag, input logic [1:0] m, input logic [7:0] f, input logic [7:0] d,
                             input logic [7:0] ew);
      add(tag, 1'b0, 1'b0, 1'b0, m, f, d, ew, 1'b0);
   endfunction

   task automatic check(input string what, input int idx, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0d: got %0d expected %0d", what, idx, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; sync = 1'b0; mode = 2'd0; fc = 8'd0; duty = 8'd0;
      w_enable = 1'b0; w_sync = 1'b0; w_mode = 2'd0; w_fc = 8'd0; w_duty = 8'd0;

      // 1: rising saw, fc=32, with a hold right after a wrap
      rs(1); s(1, 0, 32, 0);
      e(1,0,32,0,  0,0); e(1,0,32,0, 32,0); e(1,0,32,0, 64,0); e(1,0,32,0, 96,0);
      e(1,0,32,0,128,0); e(1,0,32,0,160,0); e(1,0,32,0,192,0); e(1,0,32,0,224,1);
      e(1,0,32,0,  0,0); e(1,0,32,0, 32,0); e(1,0,32,0, 64,0); e(1,0,32,0, 96,0);
      e(1,0,32,0,128,0); e(1,0,32,0,160,0); e(1,0,32,0,192,0); e(1,0,32,0,224,1);
      h(1,0,32,0,224); e(1,0,32,0,0,0); e(1,0,32,0,32,0);
      // 2: triangle, fc=64
      rs(2); s(2, 3, 64, 0);
      e(2,3,64,0,  0,0); e(2,3,64,0,128,0); e(2,3,64,0,255,0); e(2,3,64,0,127,1);
      e(2,3,64,0,  0,0); e(2,3,64,0,128,0); e(2,3,64,0,255,0); e(2,3,64,0,127,1);
      // 3: square duty=96, fc=32
      rs(3); s(3, 2, 32, 96);
      e(3,2,32,96,255,0); e(3,2,32,96,255,0); e(3,2,32,96,255,0); e(3,2,32,96,0,0);
      e(3,2,32,96,  0,0); e(3,2,32,96,  0,0); e(3,2,32,96,  0,0); e(3,2,32,96,0,1);
      e(3,2,32,96,255,0); e(3,2,32,96,255,0); e(3,2,32,96,255,0); e(3,2,32,96,0,0);
      // 4: mode request changes to falling saw at phase 96; applied after the wrap
      rs(4); s(4, 0, 32, 0);
      e(4,0,32,0,  0,0); e(4,0,32,0, 32,0); e(4,0,32,0, 64,0);
      e(4,1,32,0, 96,0); e(4,1,32,0,128,0); e(4,1,32,0,160,0); e(4,1,32,0,192,0);
      e(4,1,32,0,224,1); e(4,1,32,0,255,0); e(4,1,32,0,223,0); e(4,1,32,0,191,0);
      // 5: duty request 96 -> 224 mid-period; applied after the wrap
      rs(5); s(5, 2, 32, 96);
      e(5,2,32,224,255,0); e(5,2,32,224,255,0); e(5,2,32,224,255,0); e(5,2,32,224,0,0);
      e(5,2,32,224,  0,0); e(5,2,32,224,  0,0); e(5,2,32,224,  0,0); e(5,2,32,224,0,1);
      e(5,2,32,224,255,0); e(5,2,32,224,255,0); e(5,2,32,224,255,0); e(5,2,32,224,255,0);
      e(5,2,32,224,255,0); e(5,2,32,224,255,0); e(5,2,32,224,255,0); e(5,2,32,224,0,1);
      // 6: duty=0 is constant low
      rs(6); s(6, 2, 32, 0);
      e(6,2,32,0,0,0); e(6,2,32,0,0,0); e(6,2,32,0,0,0);
      // 7: duty=255 low only at p=255; fc=255 gives back-to-back wraps
      rs(7); s(7, 2, 255, 255);
      e(7,2,255,255,255,0); e(7,2,255,255,0,1); e(7,2,255,255,255,1); e(7,2,255,255,255,1);
      // 8: enable freeze mid-period, then sync wins over a carry
      rs(8); s(8, 0, 32, 0);
      e(8,0,32,0,0,0); e(8,0,32,0,32,0); e(8,0,32,0,64,0);
      h(8,0,32,0,64); h(8,0,32,0,64); h(8,0,32,0,64); h(8,0,32,0,64); h(8,0,32,0,64);
      e(8,0,32,0,96,0); e(8,0,32,0,128,0); e(8,0,32,0,160,0); e(8,0,32,0,192,0);
      add(8, 1'b0, 1'b1, 1'b1, 2'd0, 8'd32, 8'd0, 8'd224, 1'b0);
      e(8,0,32,0,0,0); e(8,0,32,0,32,0);
      // 9: frequency_control=0 holds phase
      rs(9); s(9, 0, 32, 0);
      e(9,0,32,0,0,0); e(9,0,32,0,32,0);
      e(9,0,0,0,64,0); e(9,0,0,0,64,0); e(9,0,0,0,64,0);
      e(9,0,32,0,64,0); e(9,0,32,0,96,0);

      foreach (vecs[i]) begin
         enable = vecs[i].en; sync = vecs[i].sy; mode = vecs[i].mode;
         fc = vecs[i].fc; duty = vecs[i].duty;
         if (vecs[i].rst) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
         $display("vec %0d sec %0d en=%0d sync=%0d mode=%0d fc=%0d duty=%0d -> wave_out=%0d wrap=%0d",
                  i, vecs[i].tag, vecs[i].en, vecs[i].sy, vecs[i].mode, vecs[i].fc, vecs[i].duty,
                  wave_out, wrap);
         check("wave_out", i, wave_out, vecs[i].exp_wave);
         check("wrap", i, {7'd0, wrap}, {7'd0, vecs[i].exp_wrap});
      end

      // Async reset between edges while running falling saw; restart is mode 0.
      reset = 1'b1; enable = 1'b0; sync = 1'b0;
      tick();
      reset = 1'b0; sync = 1'b1; mode = 2'd1; fc = 8'd32;
      tick();
      sync = 1'b0; enable = 1'b1;
      for (int k = 1; k <= 8; k++) tick();
      $display("run before reset: wave_out=%0d wrap=%0d", wave_out, wrap);
      check("pre_reset_wave", 0, wave_out, 8'd31);
      check("pre_reset_wrap", 0, {7'd0, wrap}, 8'd1);
      #2 reset = 1'b1;
      #1;
      $display("async reset mid-cycle: wave_out=%0d wrap=%0d", wave_out, wrap);
      check("async_reset_wave", 0, wave_out, 8'd0);
      check("async_reset_wrap", 0, {7'd0, wrap}, 8'd0);
      #2 reset = 1'b0;
      tick();
      $display("after reset 1: wave_out=%0d wrap=%0d", wave_out, wrap);
      check("restart_wave", 1, wave_out, 8'd0);
      tick();
      $display("after reset 2: wave_out=%0d wrap=%0d", wave_out, wrap);
      check("restart_wave", 2, wave_out, 8'd32);
      enable = 1'b0;

      // 16-bit accumulator, fc=32: one output step per 8 cycles, wrap every 2048.
      w_sync = 1'b1; w_mode = 2'd0; w_fc = 8'd32;
      tick();
      check("wide_sync_wave", 0, w_wave_out, 8'd0);
      w_sync = 1'b0; w_enable = 1'b1;
      for (int k = 1; k <= 4096; k++) begin
         logic [7:0] ew;
         logic       ewr;
         tick();
         ew  = 8'(((k - 1) / 8) % 256);
         ewr = ((k % 2048) == 0);
         if ((k % 512) == 0 || ewr || k == 9)
            $display("wide cycle %0d: wave_out=%0d wrap=%0d", k, w_wave_out, w_wrap);
         check("wide_wave", k, w_wave_out, ew);
         check("wide_wrap", k, {7'd0, w_wrap}, {7'd0, ewr});
      end
      w_enable = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
